// File: rtl/sb_cfg_pkg.sv
// sb_cfg_pkg: shared constants, FSM state type and counter sizing for the corner switch block
package sb_cfg_pkg;
    localparam int BITS_PER_MUX = 2;
    localparam int SEL_OFS = 0;
    localparam int EN_OFS = 1;
    typedef enum logic {IDLE, SHIFT} state_e;
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return w;
    endfunction
endpackage

// File: rtl/sb_route_if.sv
// sb_route_if: routing channel and grid pin bundle between the fabric and the corner switch block
interface sb_route_if #(parameter int CHAN_WIDTH = 9, parameter int MUX_TRACKS = 6);
    logic [CHAN_WIDTH-1:0] chany_top_in;
    logic [CHAN_WIDTH-1:0] chanx_right_in;
    logic [CHAN_WIDTH-1:0] chany_top_out;
    logic [CHAN_WIDTH-1:0] chanx_right_out;
    logic [MUX_TRACKS-1:0] top_pin_in;
    logic [MUX_TRACKS-1:0] right_pin_in;
    modport master(output chany_top_in, chanx_right_in, top_pin_in, right_pin_in,
                   input chany_top_out, chanx_right_out);
    modport slave(input chany_top_in, chanx_right_in, top_pin_in, right_pin_in,
                  output chany_top_out, chanx_right_out);
endinterface

// File: rtl/sb_cfg_chain.sv
// sb_cfg_chain: double-buffered config shift chain with bit counting and atomic commit
module sb_cfg_chain import sb_cfg_pkg::*; #(
    parameter int CFG_BITS = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                head_i,
    input  logic                shift_en_i,
    input  logic                commit_i,
    output logic [CFG_BITS-1:0] active_o,
    output logic                tail_o,
    output logic                valid_o,
    output logic                error_o
);
    localparam int CNT_W = clog2(CFG_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CFG_BITS + 1);
    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CFG_BITS-1:0] chain_q, chain_d, active_q, active_d;
    logic valid_q, valid_d, error_q, error_d;
    // state register; reset drops any partially shifted data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            chain_q  <= '0;
            active_q <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            chain_q  <= chain_d;
            active_q <= active_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end
    // commit beats shift; a commit is good only after exactly CFG_BITS shifts
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        chain_d  = chain_q;
        active_d = active_q;
        valid_d  = valid_q;
        error_d  = error_q;
        if (commit_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (cnt_q == CNT_FULL) begin
                active_d = chain_q;
                valid_d  = 1'b1;
                error_d  = 1'b0;
            end else begin
                error_d = 1'b1;
            end
        end else if (shift_en_i) begin
            state_d = SHIFT;
            chain_d = {chain_q[CFG_BITS-2:0], head_i};
            cnt_d   = (state_q == IDLE) ? CNT_W'(1) : (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end
    assign active_o = active_q;
    assign tail_o   = chain_q[CFG_BITS-1];
    assign valid_o  = valid_q;
    assign error_o  = error_q;
endmodule

// File: rtl/sb_corner_cfg.sv
// sb_corner_cfg: (0,0) corner switch block with pin/track muxes, pass-throughs and a committed config chain
module sb_corner_cfg import sb_cfg_pkg::*; #(
    parameter int CHAN_WIDTH = 9,
    parameter int MUX_TRACKS = 6
) (
    input  logic       prog_clk,
    input  logic       prog_reset,
    input  logic       ccff_head,
    input  logic       ccff_shift_en,
    input  logic       ccff_commit,
    sb_route_if.slave  rt,
    output logic       ccff_tail,
    output logic       cfg_valid,
    output logic       cfg_error
);
    localparam int CFG_BITS = 2 * BITS_PER_MUX * MUX_TRACKS;
    logic [CFG_BITS-1:0] active;
    logic [CHAN_WIDTH-1:0] top_o, right_o;
    sb_cfg_chain #(.CFG_BITS(CFG_BITS)) u_chain (
        .clk        (prog_clk),
        .rst        (prog_reset),
        .head_i     (ccff_head),
        .shift_en_i (ccff_shift_en),
        .commit_i   (ccff_commit),
        .active_o   (active),
        .tail_o     (ccff_tail),
        .valid_o    (cfg_valid),
        .error_o    (cfg_error)
    );
    for (genvar i = 0; i < MUX_TRACKS; i++) begin : g_mux
        localparam int TB = BITS_PER_MUX * i;
        localparam int RB = BITS_PER_MUX * (MUX_TRACKS + i);
        assign top_o[i] = active[TB+EN_OFS] ?
            (active[TB+SEL_OFS] ? rt.chanx_right_in[(i+1)%CHAN_WIDTH] : rt.top_pin_in[i]) : 1'b0;
        assign right_o[i] = active[RB+EN_OFS] ?
            (active[RB+SEL_OFS] ? rt.chany_top_in[(i+CHAN_WIDTH-1)%CHAN_WIDTH] : rt.right_pin_in[i]) : 1'b0;
    end
    for (genvar j = MUX_TRACKS; j < CHAN_WIDTH; j++) begin : g_pass
        assign top_o[j]   = rt.chanx_right_in[(j+1)%CHAN_WIDTH];
        assign right_o[j] = rt.chany_top_in[j-1];
    end
    assign rt.chany_top_out   = top_o;
    assign rt.chanx_right_out = right_o;
endmodule

// File: tb/tb_sb_corner_cfg.sv
// tb_sb_corner_cfg: randomized check of sb_corner_cfg against a queue-based reference model
module tb_sb_corner_cfg;
    logic prog_clk = 1'b0;
    logic prog_reset = 1'b1;
    logic ccff_head = 1'b0;
    logic ccff_shift_en = 1'b0;
    logic ccff_commit = 1'b0;
    logic ccff_tail, cfg_valid, cfg_error;
    int n_chk = 0;
    int n_bad = 0;
    bit m_chain[$];
    logic [23:0] m_act;
    int m_cnt;
    bit m_valid, m_err;

    sb_route_if #(.CHAN_WIDTH(9), .MUX_TRACKS(6)) rt();

    sb_corner_cfg #(.CHAN_WIDTH(9), .MUX_TRACKS(6)) dut (
        .prog_clk      (prog_clk),
        .prog_reset    (prog_reset),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_commit   (ccff_commit),
        .rt            (rt),
        .ccff_tail     (ccff_tail),
        .cfg_valid     (cfg_valid),
        .cfg_error     (cfg_error)
    );

    always #5 prog_clk = ~prog_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_chain = {};
        for (int k = 0; k < 24; k++) m_chain.push_back(1'b0);
        m_act = '0;
        m_cnt = 0;
        m_valid = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_edge(input logic h, input logic s, input logic c);
        if (c) begin
            if (m_cnt == 24) begin
                for (int k = 0; k < 24; k++) m_act[k] = m_chain[k];
                m_valid = 1'b1;
                m_err = 1'b0;
            end else begin
                m_err = 1'b1;
            end
            m_cnt = 0;
        end else if (s) begin
            m_chain.push_front(h);
            void'(m_chain.pop_back());
            m_cnt++;
        end
    endtask

    function automatic logic [8:0] exp_top();
        logic [8:0] r;
        for (int i = 0; i < 9; i++) begin
            if (i >= 6) r[i] = rt.chanx_right_in[(i+1)%9];
            else if (!m_act[2*i+1]) r[i] = 1'b0;
            else if (m_act[2*i]) r[i] = rt.chanx_right_in[(i+1)%9];
            else r[i] = rt.top_pin_in[i];
        end
        return r;
    endfunction

    function automatic logic [8:0] exp_right();
        logic [8:0] r;
        for (int i = 0; i < 9; i++) begin
            if (i >= 6) r[i] = rt.chany_top_in[i-1];
            else if (!m_act[2*(6+i)+1]) r[i] = 1'b0;
            else if (m_act[2*(6+i)]) r[i] = rt.chany_top_in[(i+8)%9];
            else r[i] = rt.right_pin_in[i];
        end
        return r;
    endfunction

    task automatic check_out(input string tag, input bit rnd);
        if (rnd) begin
            rt.chany_top_in = 9'($urandom);
            rt.chanx_right_in = 9'($urandom);
            rt.top_pin_in = 6'($urandom);
            rt.right_pin_in = 6'($urandom);
        end
        #1;
        chk({tag, ".top"}, 32'(rt.chany_top_out), 32'(exp_top()));
        chk({tag, ".right"}, 32'(rt.chanx_right_out), 32'(exp_right()));
        chk({tag, ".tail"}, 32'(ccff_tail), 32'(m_chain[23]));
        chk({tag, ".valid"}, 32'(cfg_valid), 32'(m_valid));
        chk({tag, ".error"}, 32'(cfg_error), 32'(m_err));
    endtask

    task automatic cycle(input logic h, input logic s, input logic c);
        ccff_head = h;
        ccff_shift_en = s;
        ccff_commit = c;
        @(posedge prog_clk);
        #1;
        model_edge(h, s, c);
        ccff_shift_en = 1'b0;
        ccff_commit = 1'b0;
    endtask

    task automatic load(input logic [23:0] pat, input int n, input bit fused, input bit each);
        for (int k = 0; k < n; k++) begin
            cycle(pat[23-(k%24)], 1'b1, fused && (k == n - 1));
            if (each) check_out("hold", 1'b1);
        end
        if (!fused) cycle(1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        prog_reset = 1'b1;
        model_reset();
        repeat (2) @(posedge prog_clk);
        #1;
        prog_reset = 1'b0;
    endtask

    initial begin
        logic [23:0] pat;
        model_reset();
        rt.chany_top_in = '0;
        rt.chanx_right_in = 9'h1FF;
        rt.top_pin_in = 6'h3F;
        rt.right_pin_in = 6'h3F;
        do_reset();
        #1;
        chk("rst.top_mux", 32'(rt.chany_top_out[5:0]), 32'h0);
        chk("rst.top8", 32'(rt.chany_top_out[8]), 32'h1);
        check_out("rst", 1'b0);

        load(24'h000003, 24, 1'b0, 1'b0);
        chk("one.valid", 32'(cfg_valid), 32'h1);
        rt.chanx_right_in = 9'h000;
        check_out("one.lo", 1'b0);
        chk("one.t0lo", 32'(rt.chany_top_out[0]), 32'h0);
        rt.chanx_right_in = 9'h002;
        check_out("one.hi", 1'b0);
        chk("one.t0hi", 32'(rt.chany_top_out[0]), 32'h1);
        chk("one.others", 32'(rt.chany_top_out[5:1]), 32'h0);
        repeat (4) check_out("one.rnd", 1'b1);

        load(24'hABCDEF, 23, 1'b0, 1'b0);
        chk("short.err", 32'(cfg_error), 32'h1);
        check_out("short", 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        chk("idle_commit.err", 32'(cfg_error), 32'h1);
        load(24'h000003, 24, 1'b0, 1'b0);
        chk("clear.err", 32'(cfg_error), 32'h0);
        check_out("clear", 1'b1);

        load(24'hFFFFFF, 24, 1'b0, 1'b0);
        load(24'h5A5AA5, 24, 1'b0, 1'b1);
        check_out("swap", 1'b1);

        do_reset();
        for (int k = 0; k < 24; k++) begin
            cycle(1'b1, 1'b1, 1'b0);
            chk("tail", 32'(ccff_tail), (k == 23) ? 32'h1 : 32'h0);
        end
        cycle(1'b0, 1'b1, 1'b1);
        chk("fused.valid", 32'(cfg_valid), 32'h1);
        chk("fused.tail", 32'(ccff_tail), 32'h1);
        check_out("fused", 1'b1);

        for (int k = 0; k < 10; k++) cycle(1'b1, 1'b1, 1'b0);
        #1;
        prog_reset = 1'b1;
        model_reset();
        check_out("async", 1'b1);
        #1;
        prog_reset = 1'b0;
        load(24'h3C3C3C, 24, 1'b0, 1'b0);
        chk("post_rst.valid", 32'(cfg_valid), 32'h1);
        check_out("post_rst", 1'b1);

        repeat (10) begin
            pat = 24'($urandom);
            load(pat, int'($urandom_range(22, 26)), bit'($urandom_range(0, 1)), 1'b0);
            repeat (2) check_out("rand", 1'b1);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/sb_corner_cfg.md
# sb_corner_cfg

Parametrised corner switch block for the (0,0) tile position. It routes a CHAN_WIDTH-track vertical channel (top) and horizontal channel (right) using 2:1 pin-or-track muxes plus fixed track-to-track pass-throughs. It adds a double-buffered configuration chain: bits shift in on the daisy chain without disturbing live routing and apply atomically on a commit strobe, with bit-count checking. It sits in the routing fabric on the prog_clk configuration chain.

## Interface
- CHAN_WIDTH, 9, tracks per channel side.
- MUX_TRACKS, 6, muxed tracks per side; 1 ≤ MUX_TRACKS ≤ CHAN_WIDTH; tracks MUX_TRACKS..CHAN_WIDTH-1 are pass-through.
- CFG_BITS (localparam), 4*MUX_TRACKS, 2 bits per mux × 2 sides.

Ports:
- prog_clk  in  1  configuration clock; the only clock.
- prog_reset  in  1  asynchronous, active-high reset.
- ccff_head  in  1  serial config data in.
- ccff_shift_en  in  1  shift one bit per prog_clk edge.
- ccff_commit  in  1  single-cycle strobe; copies chain to active register.
- chany_top_in  in  CHAN_WIDTH  top channel tracks, inbound.
- chanx_right_in  in  CHAN_WIDTH  right channel tracks, inbound.
- top_pin_in  in  MUX_TRACKS  grid pins eligible for top tracks.
- right_pin_in  in  MUX_TRACKS  grid pins eligible for right tracks.
- chany_top_out  out  CHAN_WIDTH  top channel tracks, outbound.
- chanx_right_out  out  CHAN_WIDTH  right channel tracks, outbound.
- ccff_tail  out  1  serial config data out = chain[CFG_BITS-1].
- cfg_valid  out  1  active config loaded.
- cfg_error  out  1  sticky bad-commit flag.

## Operation
- Mux m: top muxes m = 0..MUX_TRACKS-1 drive chany_top_out[i], i = m; right muxes m = MUX_TRACKS+i drive chanx_right_out[i]. Field: active[2m] = sel, active[2m+1] = en.
- Top mux i: en=0 → 0; sel=0 → top_pin_in[i]; sel=1 → chanx_right_in[(i+1) mod CHAN_WIDTH].
- Right mux i: en=0 → 0; sel=0 → right_pin_in[i]; sel=1 → chany_top_in[(i-1) mod CHAN_WIDTH].
- Pass-through, j ≥ MUX_TRACKS, always live, independent of config:
  - chany_top_out[j] = chanx_right_in[(j+1) mod CHAN_WIDTH].
  - chanx_right_out[j] = chany_top_in[j-1].
- Chain: on shift, chain[0] ← ccff_head, chain[k] ← chain[k-1]. The first bit shifted lands at index CFG_BITS-1 after CFG_BITS shifts.
- FSM IDLE/SHIFT, bit counter saturating at CFG_BITS+1:
  - IDLE + shift_en → SHIFT; counter = 1.
  - SHIFT + shift_en → counter+1.
  - commit in either state → IDLE, counter cleared.
- Commit check:
  - Counter == CFG_BITS: active ← chain, cfg_valid ← 1, cfg_error ← 0.
  - Otherwise (including commit in IDLE): active and cfg_valid unchanged, cfg_error ← 1.
- Simultaneous shift_en and commit: commit wins. The shift is dropped and the check uses the pre-edge counter.
- Shifting while cfg_valid=1 leaves routing on the old active config until a successful commit.

## Timing
- Reset (async assert, sync-free): chain, active, counter ← 0, FSM IDLE, ccff_tail 0, cfg_valid 0, cfg_error 0. All muxed outputs 0; pass-throughs follow inputs.
- Routing is combinational from inputs and the active register; zero-cycle latency.
- Commit sampled at edge k: active, cfg_valid and cfg_error update at edge k. Muxed outputs reflect the new config immediately after edge k.
- ccff_tail is registered; a bit presented at edge e appears on ccff_tail after edge e+CFG_BITS-1.
- Reset mid-shift discards partial data; the next shift restarts the count at 1.

## Structure
- Package sb_cfg_pkg: BITS_PER_MUX=2, SEL_OFS=0, EN_OFS=1, FSM state enum {IDLE, SHIFT}, counter-width function clog2(CFG_BITS+2).
- Sub-module sb_cfg_chain: shift chain, active register, counter, FSM, flags; outputs active[CFG_BITS] and ccff_tail.
- Muxes and pass-throughs live in the top level as generate loops.

## Test plan
Default parameters: CFG_BITS = 24.
- Reset only, drive chanx_right_in = 9'h1FF → chany_top_out[0..5] = 0, chany_top_out[8] = 1, cfg_valid = 0, cfg_error = 0.
- Shift 24 bits with active[0]=1 and active[1]=1, others 0, then commit → cfg_valid = 1 at the commit edge. chany_top_out[0] tracks chanx_right_in[1] on a toggle; other muxed outputs stay 0.
- Shift 23 bits then commit → cfg_error = 1; cfg_valid and routing unchanged. A subsequent 24-bit shift plus commit clears cfg_error.
- With an active config, shift a different 24-bit pattern → outputs hold the old routing for all 24 shift cycles and switch exactly at the commit edge.
- Hold ccff_head = 1 with shift_en for 24 edges from reset → ccff_tail = 0 through edge 23, 1 after edge 24. Assert shift_en and commit together at count 24 → commit succeeds, no extra shift.
- Assert prog_reset asynchronously mid-shift at count 10 → all state clears without a clock edge. A following 24-bit load plus commit succeeds.
